// File: rtl/alu_unit.sv
// alu_unit: two-stage pipelined RV32I integer / branch-compare execution unit.
// Stage 1 registers the issued operation, stage 2 registers the broadcast result,
// so nothing on the result bus is ever combinational from an input.
module alu_unit #(
  parameter int ROB_W  = 4,
  parameter int TYPE_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  input  logic              rs_shot,
  input  logic [31:0]       alu_r1,
  input  logic [31:0]       alu_r2,
  input  logic [ROB_W-1:0]  alu_rob_id,
  input  logic [TYPE_W-1:0] alu_work_type,
  output logic              result_ready,
  output logic [ROB_W-1:0]  result_rob_id,
  output logic [31:0]       result_value
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_SLT  = 4'd3,
    OP_SLTU = 4'd4,
    OP_XOR  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_OR   = 4'd8,
    OP_AND  = 4'd9,
    OP_BEQ  = 4'd10,
    OP_BNE  = 4'd11,
    OP_BLT  = 4'd12,
    OP_BGE  = 4'd13,
    OP_BLTU = 4'd14,
    OP_BGEU = 4'd15
  } alu_op_e;

  logic              s1_valid;
  logic [31:0]       s1_r1;
  logic [31:0]       s1_r2;
  logic [ROB_W-1:0]  s1_rob_id;
  logic [TYPE_W-1:0] s1_type;

  alu_op_e     op;
  logic        type_in_range;
  logic [4:0]  shamt;
  logic        signed_lt;
  logic        unsigned_lt;
  logic        equal;
  logic [31:0] next_value;

  assign op            = alu_op_e'(s1_type[3:0]);
  assign type_in_range = ((s1_type >> 4) == '0);
  assign shamt         = s1_r2[4:0];
  assign signed_lt     = ($signed(s1_r1) < $signed(s1_r2));
  assign unsigned_lt   = (s1_r1 < s1_r2);
  assign equal         = (s1_r1 == s1_r2);

  // Result function evaluated on stage-1 contents; encodings above 15 yield zero.
  always_comb begin
    next_value = 32'd0;
    case (op)
      OP_ADD:  next_value = s1_r1 + s1_r2;
      OP_SUB:  next_value = s1_r1 - s1_r2;
      OP_SLL:  next_value = s1_r1 << shamt;
      OP_SLT:  next_value = {31'd0, signed_lt};
      OP_SLTU: next_value = {31'd0, unsigned_lt};
      OP_XOR:  next_value = s1_r1 ^ s1_r2;
      OP_SRL:  next_value = s1_r1 >> shamt;
      OP_SRA:  next_value = 32'($signed(s1_r1) >>> shamt);
      OP_OR:   next_value = s1_r1 | s1_r2;
      OP_AND:  next_value = s1_r1 & s1_r2;
      OP_BEQ:  next_value = {31'd0, equal};
      OP_BNE:  next_value = {31'd0, ~equal};
      OP_BLT:  next_value = {31'd0, signed_lt};
      OP_BGE:  next_value = {31'd0, ~signed_lt};
      OP_BLTU: next_value = {31'd0, unsigned_lt};
      OP_BGEU: next_value = {31'd0, ~unsigned_lt};
      default: next_value = 32'd0;
    endcase
    if (!type_in_range) begin
      next_value = 32'd0;
    end
  end

  // Both pipeline stages advance together on enabled edges; a flush kills both valid bits
  // and discards the op being issued, while payloads just hold since consumers ignore them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid      <= 1'b0;
      s1_r1         <= 32'd0;
      s1_r2         <= 32'd0;
      s1_rob_id     <= '0;
      s1_type       <= '0;
      result_ready  <= 1'b0;
      result_rob_id <= '0;
      result_value  <= 32'd0;
    end else if (rdy) begin
      if (clear) begin
        s1_valid     <= 1'b0;
        result_ready <= 1'b0;
      end else begin
        s1_valid      <= rs_shot;
        s1_r1         <= alu_r1;
        s1_r2         <= alu_r2;
        s1_rob_id     <= alu_rob_id;
        s1_type       <= alu_work_type;
        result_ready  <= s1_valid;
        result_rob_id <= s1_rob_id;
        result_value  <= next_value;
      end
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed-vector bench with a queue scoreboard and a free-running monitor.
module tb_alu_unit;

  typedef struct packed {
    logic [3:0]  rob_id;
    logic [31:0] value;
  } exp_t;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst;
  logic        rdy;
  logic        clear;
  logic        rs_shot;
  logic [31:0] alu_r1;
  logic [31:0] alu_r2;
  logic [3:0]  alu_rob_id;
  logic [3:0]  alu_work_type;
  logic        result_ready;
  logic [3:0]  result_rob_id;
  logic [31:0] result_value;

  exp_t exp_q[$];
  int   assert_count = 0;
  int   fail_count = 0;
  logic new_result = 1'b0;

  alu_unit #(.ROB_W(4), .TYPE_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .clear         (clear),
    .rs_shot       (rs_shot),
    .alu_r1        (alu_r1),
    .alu_r2        (alu_r2),
    .alu_rob_id    (alu_rob_id),
    .alu_work_type (alu_work_type),
    .result_ready  (result_ready),
    .result_rob_id (result_rob_id),
    .result_value  (result_value)
  );

  // Clock runs only once enabled, so the reset state can be observed without edges.
  initial forever #5 clk = clk_en ? ~clk : clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drive one issue slot (or an idle slot) and advance to just after the sampling edge.
  task automatic apply_stimulus(input logic shot, input logic clr, input logic [3:0] wtype,
                                input logic [31:0] r1, input logic [31:0] r2, input logic [3:0] id,
                                input logic expect_it, input logic [31:0] exp_val);
    exp_t e;
    rs_shot       = shot;
    clear         = clr;
    alu_work_type = wtype;
    alu_r1        = r1;
    alu_r2        = r2;
    alu_rob_id    = id;
    if (expect_it) begin
      e.rob_id = id;
      e.value  = exp_val;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      apply_stimulus(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0);
    end
  endtask

  // A result is fresh only on the first negedge following an enabled, out-of-reset edge.
  always @(posedge clk) new_result <= rdy && rst;

  // Monitor: every fresh result must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (new_result && result_ready) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_result_id", {28'd0, result_rob_id}, 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_output("result_rob_id", {28'd0, result_rob_id}, {28'd0, e.rob_id});
        check_output("result_value", result_value, e.value);
      end
    end
  end

  initial begin
    rdy = 1'b1;
    clear = 1'b0;
    rs_shot = 1'b0;
    alu_r1 = 32'd0;
    alu_r2 = 32'd0;
    alu_rob_id = 4'd0;
    alu_work_type = 4'd0;

    // Reset without any clock edge
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    check_output("reset_ready", {31'd0, result_ready}, 32'd0);
    check_output("reset_rob_id", {28'd0, result_rob_id}, 32'd0);
    check_output("reset_value", result_value, 32'd0);
    #1 clk_en = 1'b1;
    #2 rst = 1'b1;
    @(posedge clk);
    #1;

    // First op after reset
    apply_stimulus(1'b1, 1'b0, 4'd0, 32'd5, 32'd7, 4'd3, 1'b1, 32'd12);
    idle(3);

    // Back-to-back issue
    apply_stimulus(1'b1, 1'b0, 4'd1,  32'h0000_0000, 32'h0000_0001, 4'd1, 1'b1, 32'hFFFF_FFFF);
    apply_stimulus(1'b1, 1'b0, 4'd7,  32'h8000_0000, 32'h0000_0004, 4'd2, 1'b1, 32'hF800_0000);
    apply_stimulus(1'b1, 1'b0, 4'd4,  32'h0000_0001, 32'hFFFF_FFFF, 4'd4, 1'b1, 32'd1);
    apply_stimulus(1'b1, 1'b0, 4'd12, 32'hFFFF_FFFF, 32'h0000_0000, 4'd5, 1'b1, 32'd1);
    idle(3);

    // Shift masking and remaining operations
    apply_stimulus(1'b1, 1'b0, 4'd2,  32'h0000_0001, 32'h0000_0023, 4'd7,  1'b1, 32'h0000_0008);
    apply_stimulus(1'b1, 1'b0, 4'd5,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd8,  1'b1, 32'hFF00_FF00);
    apply_stimulus(1'b1, 1'b0, 4'd8,  32'h00FF_0000, 32'h0000_FF00, 4'd9,  1'b1, 32'h00FF_FF00);
    apply_stimulus(1'b1, 1'b0, 4'd9,  32'hFFFF_0000, 32'h0F0F_0F0F, 4'd10, 1'b1, 32'h0F0F_0000);
    apply_stimulus(1'b1, 1'b0, 4'd6,  32'h8000_0000, 32'h0000_0004, 4'd11, 1'b1, 32'h0800_0000);
    apply_stimulus(1'b1, 1'b0, 4'd3,  32'hFFFF_FFFF, 32'h0000_0001, 4'd12, 1'b1, 32'd1);
    apply_stimulus(1'b1, 1'b0, 4'd4,  32'hFFFF_FFFF, 32'h0000_0001, 4'd13, 1'b1, 32'd0);
    apply_stimulus(1'b1, 1'b0, 4'd11, 32'h0000_0003, 32'h0000_0003, 4'd14, 1'b1, 32'd0);
    apply_stimulus(1'b1, 1'b0, 4'd13, 32'h8000_0000, 32'h7FFF_FFFF, 4'd15, 1'b1, 32'd0);
    apply_stimulus(1'b1, 1'b0, 4'd14, 32'h8000_0000, 32'h7FFF_FFFF, 4'd0,  1'b1, 32'd0);
    apply_stimulus(1'b1, 1'b0, 4'd15, 32'h8000_0000, 32'h7FFF_FFFF, 4'd1,  1'b1, 32'd1);
    apply_stimulus(1'b1, 1'b0, 4'd0,  32'hFFFF_FFFF, 32'h0000_0002, 4'd2,  1'b1, 32'd1);
    apply_stimulus(1'b1, 1'b0, 4'd10, 32'h0000_0001, 32'h0000_0002, 4'd3,  1'b1, 32'd0);
    idle(3);

    // rdy stall with an op in stage 1
    apply_stimulus(1'b1, 1'b0, 4'd10, 32'd9, 32'd9, 4'd6, 1'b1, 32'd1);
    rs_shot = 1'b0;
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("stall_ready_low", {31'd0, result_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    rdy = 1'b1;
    @(posedge clk);
    #1;
    // Hold the fresh result under rdy=0; it must stay visible
    rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_output("stall_hold_ready", {31'd0, result_ready}, 32'd1);
      check_output("stall_hold_rob_id", {28'd0, result_rob_id}, 32'd6);
    end
    @(posedge clk);
    #1;
    rdy = 1'b1;
    idle(3);

    // Flush: A killed in stage 1, B discarded at issue, C flows normally
    apply_stimulus(1'b1, 1'b0, 4'd0, 32'd1, 32'd1, 4'd4, 1'b0, 32'd0);
    apply_stimulus(1'b1, 1'b1, 4'd0, 32'd2, 32'd2, 4'd5, 1'b0, 32'd0);
    apply_stimulus(1'b1, 1'b0, 4'd0, 32'd3, 32'd4, 4'd6, 1'b1, 32'd7);
    idle(4);

    // Async reset while a result is showing and another op sits in stage 1
    apply_stimulus(1'b1, 1'b0, 4'd0, 32'd10, 32'd20, 4'd7, 1'b1, 32'd30);
    apply_stimulus(1'b1, 1'b0, 4'd1, 32'd5,  32'd3,  4'd8, 1'b0, 32'd0);
    rs_shot = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_output("async_reset_ready", {31'd0, result_ready}, 32'd0);
    check_output("async_reset_rob_id", {28'd0, result_rob_id}, 32'd0);
    check_output("async_reset_value", result_value, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    idle(4);
    apply_stimulus(1'b1, 1'b0, 4'd0, 32'd100, 32'd1, 4'd9, 1'b1, 32'd101);
    idle(4);

    check_output("scoreboard_drain", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/alu_unit.md
# alu_unit

Two-stage pipelined integer execution unit on the far end of the reservation station's issue port. It accepts at most one ready operation per cycle: operands, ROB id and work type. It computes the RV32I integer or branch-compare result and broadcasts it with its ROB id back to the reservation station, which uses the same bus for the ROB and for wake-up. There is no backpressure: every issued op completes unless a flush kills it.

## Interface
- ROB_W, default 4: ROB id width; must equal the codebase `robsize`.
- TYPE_W, default 4: work-type width; must equal `rs_type_size`.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global enable; when low, all state holds.
- clear  in  1  pipeline flush (mispredict); synchronous, qualified by rdy.
- rs_shot  in  1  issue valid.
- alu_r1  in  32  operand 1.
- alu_r2  in  32  operand 2.
- alu_rob_id  in  ROB_W  destination ROB id.
- alu_work_type  in  TYPE_W  operation code.
- result_ready  out  1  result valid; one cycle per op.
- result_rob_id  out  ROB_W  ROB id of the result.
- result_value  out  32  result data.

## Operation
- Work type encoding:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
  - 10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 BLTU, 15 BGEU.
- Arithmetic rules:
  - ADD and SUB are modulo 2^32.
  - Shift amount is alu_r2[4:0]; upper bits are ignored.
  - SRA replicates bit 31.
  - SLT, BLT and BGE compare signed; SLTU, BLTU and BGEU compare unsigned.
  - SLT/SLTU and all branch types return 32'd1 (true/taken) or 32'd0.
- Stage 1 (S1) holds the input registers: s1_valid, r1, r2, rob_id and type, loaded from the ports when rdy=1. s1_valid <= rs_shot.
- Stage 2 (S2) holds the output registers. At each rdy=1 edge:
  - result_ready <= s1_valid;
  - result_rob_id <= s1 rob_id;
  - result_value <= f(type, r1, r2), computed from S1 contents.
- Payload registers may load while their valid bit is 0. Consumers look only at result_ready.
- clear=1 with rdy=1 at an edge:
  - s1_valid <= 0 and result_ready <= 0;
  - the op presented on rs_shot in that cycle is discarded.
  - clear overrides all other updates.
- rdy=0: no register changes, clear is ignored, and outputs keep their last values. A pending result_ready=1 therefore stays visible until the next rdy=1 edge consumes it.
- Reset (rst=0, asynchronous): s1_valid=0, S1 payload=0, result_ready=0, result_rob_id=0, result_value=0. All outputs are 0 immediately on assertion, with no clock required.
- Reset released mid-stream: the first rs_shot sampled after release is processed normally. No residue from before reset may appear.
- Unused encodings: none, because all 16 values are defined. If TYPE_W > 4 and the high bits are nonzero, the result is 32'd0 and result_ready still asserts.

## Timing
- Latency: an op sampled with rs_shot=1 at rdy-edge E produces result_ready=1 from edge E+1 until edge E+2, with the matching rob_id and value.
- Throughput: one op per rdy-cycle; back-to-back issue gives back-to-back results in issue order.
- Stalls: rdy-low cycles between E and E+1 stretch latency without losing data.
- The result path is registered, so output is never combinational from any input. This is required because the reservation station compares result_rob_id against entry dependencies in the same cycle as issue.
- clear at edge E+1 kills an op issued at E. clear at edge E+2 does not retract a result already shown after E+1; result_ready simply drops.

## Test plan
- Reset: with rst=0 and no clock, all outputs read 0. Release reset, issue ADD with r1=5, r2=7, rob_id=3 -> two edges later result_ready=1, rob_id=3, value=12 for exactly one cycle.
- Back-to-back issue:
  - stimulus: SUB(0,1) id1; SRA(0x80000000,4) id2; SLTU(1,0xFFFFFFFF) id4; BLT(0xFFFFFFFF,0) id5 on four consecutive cycles;
  - response: results on four consecutive cycles, 0xFFFFFFFF id1, 0xF8000000 id2, 1 id4, 1 id5.
- Shift masking: SLL with r1=1, r2=0x23 -> value 0x8.
- rdy stall: issue BEQ(9,9) id6, then hold rdy=0 for 3 cycles after the first edge -> result_ready stays 0 during the stall, then value=1 id6 one rdy-edge after rdy returns. An asserted result held under rdy=0 stays asserted.
- Flush: issue op A at E, op B at E+1 with clear=1 at E+1 -> no result for A or B. An op C issued at E+2 appears after E+3 normally.
- Async reset mid-operation: drop rst between two clock edges while result_ready=1 -> outputs clear to 0 immediately. No stale result appears after release.
